logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter.sv | 112 +++++++++++
 tb/tb_logic_unit_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that time-shares one bitwise logic unit among four requesters.
// Each transaction runs IDLE -> GRANT -> RESULT, so one result is produced every three cycles.
module logic_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [3:0]         req,
  input  logic [11:0]        op,
  input  logic [4*WIDTH-1:0] a,
  input  logic [4*WIDTH-1:0] b,
  output logic [3:0]         gnt,
  output logic               valid,
  output logic [WIDTH-1:0]   result,
  output logic [1:0]         rid,
  output logic               err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [1:0]       pick;
  logic [2:0]       op_l;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic [WIDTH-1:0] alu;

  logic [2:0]       op_arr [4];
  logic [WIDTH-1:0] a_arr  [4];
  logic [WIDTH-1:0] b_arr  [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign op_arr[gi] = op[3*gi +: 3];
    assign a_arr[gi]  = a[WIDTH*gi +: WIDTH];
    assign b_arr[gi]  = b[WIDTH*gi +: WIDTH];
  end

  // Scan from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
  end

  always_comb begin
    case (op_l)
      3'd0:    alu = a_l & b_l;
      3'd1:    alu = a_l | b_l;
      3'd2:    alu = ~a_l;
      3'd3:    alu = ~(a_l & b_l);
      3'd4:    alu = ~(a_l | b_l);
      3'd5:    alu = a_l ^ b_l;
      3'd6:    alu = ~(a_l ^ b_l);
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      win    <= 2'd0;
      op_l   <= 3'd0;
      a_l    <= '0;
      b_l    <= '0;
      gnt    <= 4'b0;
      valid  <= 1'b0;
      result <= '0;
      rid    <= 2'd0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            win   <= pick;
            op_l  <= op_arr[pick];
            a_l   <= a_arr[pick];
            b_l   <= b_arr[pick];
            gnt   <= 4'b0001 << pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          gnt    <= 4'b0;
          valid  <= 1'b1;
          result <= alu;
          rid    <= win;
          err    <= (op_l == 3'd7);
          state  <= RESULT;
        end
        RESULT: begin
          valid <= 1'b0;
          err   <= 1'b0;
          ptr   <= win + 2'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-schedule reference model.
module tb_logic_unit_arbiter;
  localparam int WIDTH = 8;

  logic               clk  = 1'b0;
  logic               clrn = 1'b1;
  logic [3:0]         req  = 4'b0;
  logic [11:0]        op   = 12'b0;
  logic [4*WIDTH-1:0] a    = '0;
  logic [4*WIDTH-1:0] b    = '0;
  logic [3:0]         gnt;
  logic               valid;
  logic [WIDTH-1:0]   result;
  logic [1:0]         rid;
  logic               err;
  logic               busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clrn(clrn), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .valid(valid), .result(result), .rid(rid), .err(err), .busy(busy)
  );

  // Reference model: a transaction starting at edge s owns cycles s+1 (grant) and s+2 (result);
  // the next one may start at edge s+3.
  int               e_now   = 0;
  int               start_e = -100;
  int               m_ptr   = 0;
  int               m_win   = 0;
  logic [WIDTH-1:0] m_res   = '0;
  logic             m_err   = 1'b0;
  logic [WIDTH-1:0] last_result = '0;
  logic [1:0]       last_rid    = 2'd0;
  logic [3:0]       exp_gnt;
  logic             exp_valid, exp_err, exp_busy;
  logic [WIDTH-1:0] exp_result;
  logic [1:0]       exp_rid;
  bit               auto_drop = 1'b1;

  function automatic logic [WIDTH-1:0] ref_op(input int code, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    case (code)
      0:       ref_op = x & y;
      1:       ref_op = x | y;
      2:       ref_op = ~x;
      3:       ref_op = ~(x & y);
      4:       ref_op = ~(x | y);
      5:       ref_op = x ^ y;
      6:       ref_op = ~(x ^ y);
      default: ref_op = '0;
    endcase
  endfunction

  task automatic model_reset();
    start_e     = -100;
    m_ptr       = 0;
    last_result = '0;
    last_rid    = 2'd0;
  endtask

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic tick();
    if (e_now >= start_e + 3 && req != 4'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (req[(m_ptr + k) % 4]) begin
          m_win = (m_ptr + k) % 4;
          break;
        end
      end
      m_res   = ref_op(int'(op[3*m_win +: 3]), a[WIDTH*m_win +: WIDTH], b[WIDTH*m_win +: WIDTH]);
      m_err   = (op[3*m_win +: 3] == 3'd7);
      m_ptr   = (m_win + 1) % 4;
      start_e = e_now;
    end
    @(posedge clk);
    @(negedge clk);
    exp_gnt   = (e_now == start_e) ? 4'(1 << m_win) : 4'b0;
    exp_valid = (e_now == start_e + 1);
    exp_busy  = (e_now == start_e) || (e_now == start_e + 1);
    exp_err   = exp_valid && m_err;
    if (exp_valid) begin
      last_result = m_res;
      last_rid    = 2'(m_win);
      $display("txn rid=%0d result=%h err=%b", rid, result, err);
    end
    exp_result = last_result;
    exp_rid    = last_rid;
    e_now++;
    if (auto_drop) req = req & ~exp_gnt;
  endtask

  task automatic test_reset();
    #2 clrn = 1'b0;
    #1;
    if (gnt !== 4'b0)    begin mismatched++; $display("FAIL reset_gnt got=%b want=0", gnt); end
    compared++;
    if (valid !== 1'b0)  begin mismatched++; $display("FAIL reset_valid got=%b want=0", valid); end
    compared++;
    if (result !== '0)   begin mismatched++; $display("FAIL reset_result got=%h want=0", result); end
    compared++;
    if (rid !== 2'd0)    begin mismatched++; $display("FAIL reset_rid got=%0d want=0", rid); end
    compared++;
    if (err !== 1'b0)    begin mismatched++; $display("FAIL reset_err got=%b want=0", err); end
    compared++;
    if (busy !== 1'b0)   begin mismatched++; $display("FAIL reset_busy got=%b want=0", busy); end
    compared++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    op[2:0] = 3'd0; a[7:0] = 8'hF0; b[7:0] = 8'h3C; req = 4'b0001;
    tick();
    if (gnt !== 4'b0001) begin mismatched++; $display("FAIL basic_gnt got=%b want=0001", gnt); end
    compared++;
    if (busy !== 1'b1)   begin mismatched++; $display("FAIL basic_busy got=%b want=1", busy); end
    compared++;
    tick();
    if (valid !== 1'b1 || result !== 8'h30 || rid !== 2'd0 || err !== 1'b0 || gnt !== 4'b0) begin
      mismatched++;
      $display("FAIL basic_result got v=%b r=%h id=%0d e=%b g=%b want v=1 r=30 id=0 e=0 g=0000",
               valid, result, rid, err, gnt);
    end
    compared++;
    tick();
    if (valid !== 1'b0 || result !== 8'h30 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_hold got v=%b r=%h busy=%b want v=0 r=30 busy=0", valid, result, busy);
    end
    compared++;
  endtask

  task automatic test_ops();
    logic [7:0] want [7] = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55};
    for (int i = 0; i < 7; i++) begin
      op[8:6] = 3'(i); a[23:16] = 8'hA5; b[23:16] = 8'h0F; req = 4'b0100;
      tick();
      tick();
      if (valid !== 1'b1 || result !== want[i] || rid !== 2'd2) begin
        mismatched++;
        $display("FAIL ops_%0d got v=%b r=%h id=%0d want v=1 r=%h id=2", i, valid, result, rid, want[i]);
      end
      compared++;
      tick();
    end
  endtask

  task automatic test_reserved();
    op[11:9] = 3'd7; a[31:24] = 8'($urandom); b[31:24] = 8'($urandom); req = 4'b1000;
    tick();
    tick();
    if (valid !== 1'b1 || err !== 1'b1 || result !== 8'h00 || rid !== 2'd3) begin
      mismatched++;
      $display("FAIL reserved got v=%b e=%b r=%h id=%0d want v=1 e=1 r=00 id=3", valid, err, result, rid);
    end
    compared++;
    tick();
    if (err !== 1'b0) begin mismatched++; $display("FAIL reserved_errclr got=%b want=0", err); end
    compared++;
    op[11:9] = 3'd1; a[31:24] = 8'h12; b[31:24] = 8'h81; req = 4'b1000;
    tick();
    tick();
    if (valid !== 1'b1 || err !== 1'b0 || result !== 8'h93) begin
      mismatched++;
      $display("FAIL reserved_next got v=%b e=%b r=%h want v=1 e=0 r=93", valid, err, result);
    end
    compared++;
    tick();
  endtask

  task automatic test_all_req();
    int n_valid = 0;
    auto_drop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op[3*i +: 3] = 3'($urandom_range(0, 6)); a[8*i +: 8] = 8'($urandom); b[8*i +: 8] = 8'($urandom);
    end
    req = 4'b1111;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (gnt !== exp_gnt || valid !== exp_valid || result !== exp_result) begin
        mismatched++;
        $display("FAIL allreq_t%0d got g=%b v=%b r=%h want g=%b v=%b r=%h",
                 t, gnt, valid, result, exp_gnt, exp_valid, exp_result);
      end
      compared++;
      if (valid) begin
        if (rid !== 2'(n_valid % 4)) begin
          mismatched++;
          $display("FAIL allreq_rid got=%0d want=%0d", rid, n_valid % 4);
        end
        compared++;
        n_valid++;
      end
      for (int i = 0; i < 4; i++) begin
        if (exp_gnt[i]) begin
          op[3*i +: 3] = 3'($urandom_range(0, 6)); a[8*i +: 8] = 8'($urandom); b[8*i +: 8] = 8'($urandom);
        end
      end
      if (t == 13) req = 4'b0;
    end
    if (n_valid != 5) begin mismatched++; $display("FAIL allreq_count got=%0d want=5", n_valid); end
    compared++;
    auto_drop = 1'b1;
    tick();
  endtask

  task automatic test_operand_change();
    logic [2:0] o0 = 3'($urandom_range(0, 6));
    logic [7:0] x0 = 8'($urandom);
    logic [7:0] y0 = 8'($urandom);
    logic [7:0] want;
    want = ref_op(int'(o0), x0, y0);
    op[2:0] = o0; a[7:0] = x0; b[7:0] = y0; req = 4'b0001;
    tick();
    op[2:0] = o0 + 3'd1; a[7:0] = ~x0; b[7:0] = x0 ^ 8'h5A;
    tick();
    if (valid !== 1'b1 || result !== want) begin
      mismatched++;
      $display("FAIL opchange got v=%b r=%h want v=1 r=%h", valid, result, want);
    end
    compared++;
    tick();
  endtask

  task automatic test_reset_in_grant();
    op[5:3] = 3'd5; a[15:8] = 8'h3C; b[15:8] = 8'hFF; req = 4'b0010;
    tick();
    if (gnt !== 4'b0010) begin mismatched++; $display("FAIL rstgnt_pre got=%b want=0010", gnt); end
    compared++;
    #2 clrn = 1'b0;
    #1;
    if (gnt !== 4'b0 || valid !== 1'b0 || result !== '0 || rid !== 2'd0 || err !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rstgnt_async got g=%b v=%b r=%h id=%0d e=%b busy=%b want all 0",
               gnt, valid, result, rid, err, busy);
    end
    compared++;
    model_reset();
    op[8:6] = 3'd1; a[23:16] = 8'h11; b[23:16] = 8'h22; req = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    tick();
    if (gnt !== 4'b0010 || valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rstgnt_next got g=%b v=%b want g=0010 v=0", gnt, valid);
    end
    compared++;
    tick();
    if (valid !== 1'b1 || rid !== 2'd1 || result !== exp_result) begin
      mismatched++;
      $display("FAIL rstgnt_result got v=%b id=%0d r=%h want v=1 id=1 r=%h", valid, rid, result, exp_result);
    end
    compared++;
    req = 4'b0;
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) begin
          op[3*i +: 3] = 3'($urandom_range(0, 7)); a[8*i +: 8] = 8'($urandom); b[8*i +: 8] = 8'($urandom);
          if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
        end
      end
      if (t == 200 || t == 301) begin
        #2 clrn = 1'b0;
        #1;
        if (gnt !== 4'b0 || valid !== 1'b0 || result !== '0 || rid !== 2'd0 || err !== 1'b0 || busy !== 1'b0) begin
          mismatched++;
          $display("FAIL rand_async t=%0d got g=%b v=%b r=%h id=%0d e=%b busy=%b want all 0",
                   t, gnt, valid, result, rid, err, busy);
        end
        compared++;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
      end
      tick();
      if (gnt !== exp_gnt || valid !== exp_valid || result !== exp_result ||
          rid !== exp_rid || err !== exp_err || busy !== exp_busy) begin
        mismatched++;
        $display("FAIL rand_t%0d got g=%b v=%b r=%h id=%0d e=%b busy=%b want g=%b v=%b r=%h id=%0d e=%b busy=%b",
                 t, gnt, valid, result, rid, err, busy,
                 exp_gnt, exp_valid, exp_result, exp_rid, exp_err, exp_busy);
      end
      compared++;
      if (!$onehot0(gnt)) begin mismatched++; $display("FAIL rand_onehot t=%0d got=%b want<=1 bit", t, gnt); end
      compared++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ops();
    test_reserved();
    test_all_req();
    test_operand_change();
    test_reset_in_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
